// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared constants, types and helpers for the snake game food placement logic.
//   GRID_W/GRID_H : playfield size in cells
//   CELL_PX       : pixel pitch of one cell, OFFSET_PX : pixel position of cell 0
//   MAX_LEN       : maximum snake segments, IDX_W/LEN_W derived widths
//   MAX_RETRY     : rejected candidates tolerated before place_fail raises
// -----------------------------------------------------------------------------
package snake_pkg;

    localparam int GRID_W    = 21;
    localparam int GRID_H    = 20;
    localparam int CELL_PX   = 25;
    localparam int OFFSET_PX = 2;
    localparam int MAX_LEN   = 64;
    localparam int MAX_RETRY = 15;

    localparam int IDX_W    = $clog2(MAX_LEN);
    localparam int LEN_W    = IDX_W + 1;
    localparam int RETRY_W  = $clog2(MAX_RETRY + 2);
    localparam int GRID_MAX = (GRID_W > GRID_H) ? GRID_W : GRID_H;

    typedef logic [9:0] pix_t;

    // Pixel position of cell (1,1): where the food sits out of reset.
    localparam pix_t RESET_PIX = 10'd27;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        SCAN   = 2'd2,
        COMMIT = 2'd3
    } food_state_t;

    // True when pixel coordinate c is exactly the origin of one of the first
    // 'cells' grid cells. Built as a set of constant comparators so no
    // divider is needed for the alignment / range test.
    function automatic logic on_grid(input pix_t c, input int cells);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < GRID_MAX; i++) begin
            if ((i < cells) && (c == pix_t'(i * CELL_PX + OFFSET_PX))) begin
                ok = 1'b1;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/food_collision_scan.sv
// -----------------------------------------------------------------------------
// food_collision_scan
// Walks the snake body RAM and reports whether the candidate food cell lies on
// any segment. The body RAM has a one-cycle registered read, so the segment
// returned in a given cycle belongs to the address issued the cycle before.
// Ports:
//   clock, reset  : system clock, asynchronous active-high reset
//   start_i       : pulse, begins a scan of len_i segments against cand_*_i
//   len_i         : segment count (held stable by the caller during the scan)
//   cand_x_i/y_i  : candidate food position in pixels
//   seg_x_i/y_i   : segment position read back from the body RAM
//   seg_idx_o     : body RAM read address
//   done_o        : one-cycle pulse, scan finished, hit_o valid
//   hit_o         : candidate collided with a segment
// -----------------------------------------------------------------------------
module food_collision_scan
    import snake_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  pix_t             cand_x_i,
    input  pix_t             cand_y_i,
    input  pix_t             seg_x_i,
    input  pix_t             seg_y_i,
    output logic [IDX_W-1:0] seg_idx_o,
    output logic             done_o,
    output logic             hit_o
);

    logic             busy_q, busy_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic             acc_q, acc_d;
    logic             done_q, done_d;
    logic             hit_q, hit_d;
    logic             cmp_s;
    logic             last_s;

    // Compare the segment returned for address idx_q-1; address 0 has no
    // data behind it yet. idx runs 0..len so a length of 0 is a single cycle.
    always_comb begin
        cmp_s  = (idx_q != '0) && (seg_x_i == cand_x_i) && (seg_y_i == cand_y_i);
        last_s = (idx_q == len_i);
        busy_d = busy_q;
        idx_d  = idx_q;
        acc_d  = acc_q;
        done_d = 1'b0;
        hit_d  = hit_q;
        if (start_i) begin
            busy_d = 1'b1;
            idx_d  = '0;
            acc_d  = 1'b0;
            hit_d  = 1'b0;
        end else if (busy_q) begin
            if (last_s) begin
                busy_d = 1'b0;
                idx_d  = '0;
                done_d = 1'b1;
                hit_d  = acc_q | cmp_s;
            end else begin
                idx_d = idx_q + LEN_W'(1);
                acc_d = acc_q | cmp_s;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Scan state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            idx_q  <= '0;
            acc_q  <= 1'b0;
            done_q <= 1'b0;
            hit_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            done_q <= done_d;
            hit_q  <= hit_d;
        end
    end

    // The final count value (len = MAX_LEN) never addresses the RAM.
    assign seg_idx_o = idx_q[IDX_W-1:0];
    assign done_o    = done_q;
    assign hit_o     = hit_q;

endmodule

// File: rtl/food_placer.sv
// -----------------------------------------------------------------------------
// food_placer
// Places the food cell for the snake game. Random pixel candidates are checked
// for grid alignment/range, then scanned against the snake body; the first
// clean candidate is committed and held for the renderer until eaten.
// Optional build macro: FOOD_EAT_COUNT_EN adds eat_count[15:0], a wrapping
// count of eaten pulses accepted while the food was placed.
// Ports:
//   clock, reset        : system clock, asynchronous active-high reset
//   randNumX/randNumY   : candidate food position from the random generator
//   eaten               : pulse, snake head consumed the food
//   snake_len           : current segment count 0..MAX_LEN
//   seg_idx             : body RAM read address
//   seg_x/seg_y         : body RAM read data, one cycle after seg_idx
//   foodX/foodY         : committed food position in pixels
//   food_valid          : foodX/foodY hold a placed food
//   place_fail          : sticky, too many rejections in this placement
// -----------------------------------------------------------------------------
module food_placer
    import snake_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [9:0]       randNumX,
    input  logic [9:0]       randNumY,
    input  logic             eaten,
    input  logic [LEN_W-1:0] snake_len,
    output logic [IDX_W-1:0] seg_idx,
    input  logic [9:0]       seg_x,
    input  logic [9:0]       seg_y,
    output logic [9:0]       foodX,
    output logic [9:0]       foodY,
`ifdef FOOD_EAT_COUNT_EN
    output logic [15:0]      eat_count,
`endif
    output logic             food_valid,
    output logic             place_fail
);

    localparam logic [RETRY_W-1:0] RETRY_SAT = RETRY_W'(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    food_state_t        state_q, state_d;
    pix_t               cand_x_q, cand_x_d;
    pix_t               cand_y_q, cand_y_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               place_fail_q, place_fail_d;
    pix_t               food_x_q, food_x_d;
    pix_t               food_y_q, food_y_d;
    logic               food_valid_q, food_valid_d;
`ifdef FOOD_EAT_COUNT_EN
    logic [15:0]        eat_count_q, eat_count_d;
`endif

    logic               scan_start_s;
    logic               scan_done_s;
    logic               scan_hit_s;
    logic               cand_ok_s;
    logic [RETRY_W-1:0] retry_inc_s;
    logic               fail_set_s;

    food_collision_scan u_scan (
        .clock     (clock),
        .reset     (reset),
        .start_i   (scan_start_s),
        .len_i     (len_q),
        .cand_x_i  (cand_x_q),
        .cand_y_i  (cand_y_q),
        .seg_x_i   (seg_x),
        .seg_y_i   (seg_y),
        .seg_idx_o (seg_idx),
        .done_o    (scan_done_s),
        .hit_o     (scan_hit_s)
    );

    // Next-state logic for the placement FSM and its output registers.
    always_comb begin
        cand_ok_s    = on_grid(randNumX, GRID_W) && on_grid(randNumY, GRID_H);
        // Saturating retry count; place_fail follows it past MAX_RETRY.
        retry_inc_s  = (retry_q == RETRY_SAT) ? retry_q : (retry_q + RETRY_W'(1));
        fail_set_s   = (retry_inc_s > RETRY_LIM);
        scan_start_s = 1'b0;
        state_d      = state_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        len_d        = len_q;
        retry_d      = retry_q;
        place_fail_d = place_fail_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
`ifdef FOOD_EAT_COUNT_EN
        eat_count_d  = eat_count_q;
`endif
        case (state_q)
            IDLE: begin
                if (eaten) begin
                    state_d      = SAMPLE;
                    food_valid_d = 1'b0;
`ifdef FOOD_EAT_COUNT_EN
                    eat_count_d  = eat_count_q + 16'd1;
`endif
                end else begin
                    food_valid_d = 1'b1;
                end
            end
            SAMPLE: begin
                // Latch every sample; len_q stays frozen for the whole scan.
                cand_x_d = randNumX;
                cand_y_d = randNumY;
                len_d    = snake_len;
                if (cand_ok_s) begin
                    state_d      = SCAN;
                    scan_start_s = 1'b1;
                end else begin
                    retry_d      = retry_inc_s;
                    place_fail_d = place_fail_q | fail_set_s;
                end
            end
            SCAN: begin
                if (scan_done_s) begin
                    if (scan_hit_s) begin
                        state_d      = SAMPLE;
                        retry_d      = retry_inc_s;
                        place_fail_d = place_fail_q | fail_set_s;
                    end else begin
                        state_d = COMMIT;
                    end
                end else begin
                    state_d = SCAN;
                end
            end
            COMMIT: begin
                food_x_d     = cand_x_q;
                food_y_d     = cand_y_q;
                food_valid_d = 1'b1;
                retry_d      = '0;
                place_fail_d = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = SAMPLE;
            end
        endcase
    end

    // Placement FSM state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= SAMPLE;
            cand_x_q     <= RESET_PIX;
            cand_y_q     <= RESET_PIX;
            len_q        <= '0;
            retry_q      <= '0;
            place_fail_q <= 1'b0;
            food_x_q     <= RESET_PIX;
            food_y_q     <= RESET_PIX;
            food_valid_q <= 1'b0;
`ifdef FOOD_EAT_COUNT_EN
            eat_count_q  <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            len_q        <= len_d;
            retry_q      <= retry_d;
            place_fail_q <= place_fail_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
`ifdef FOOD_EAT_COUNT_EN
            eat_count_q  <= eat_count_d;
`endif
        end
    end

    assign foodX      = food_x_q;
    assign foodY      = food_y_q;
    assign food_valid = food_valid_q;
    assign place_fail = place_fail_q;
`ifdef FOOD_EAT_COUNT_EN
    assign eat_count  = eat_count_q;
`endif

endmodule

// File: tb/tb_food_placer.sv
// -----------------------------------------------------------------------------
// tb_food_placer
// Randomised bench for food_placer. For each placement a reference model
// decides, from the candidate schedule and the body contents, which candidate
// is committed, on which clock edge food_valid rises and on which edge
// place_fail must be set. Those expectations go into a scoreboard queue; a
// monitor on the falling edge pops and compares when food_valid appears.
// Build with +define+FOOD_EAT_COUNT_EN to also check eat_count.
// -----------------------------------------------------------------------------
module tb_food_placer;

    typedef struct {
        int fx;
        int fy;
        int commit_edge;
        int pf_edge;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  randNumX, randNumY;
    logic        eaten;
    logic [6:0]  snake_len;
    logic [5:0]  seg_idx;
    logic [9:0]  seg_x, seg_y;
    logic [9:0]  foodX, foodY;
    logic        food_valid, place_fail;
`ifdef FOOD_EAT_COUNT_EN
    logic [15:0] eat_count;
    int          exp_eat = 0;
`endif

    logic [9:0]  body_x [64];
    logic [9:0]  body_y [64];
    int          edge_n = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        sbq[$];
    int          rx_at[$], ry_at[$], len_at[$];
    bit          eat_at[$];
    int          fqx[$], fqy[$];
    int          force_hits = 0;

    food_placer dut (
        .clock      (clock),
        .reset      (reset),
        .randNumX   (randNumX),
        .randNumY   (randNumY),
        .eaten      (eaten),
        .snake_len  (snake_len),
        .seg_idx    (seg_idx),
        .seg_x      (seg_x),
        .seg_y      (seg_y),
        .foodX      (foodX),
        .foodY      (foodY),
`ifdef FOOD_EAT_COUNT_EN
        .eat_count  (eat_count),
`endif
        .food_valid (food_valid),
        .place_fail (place_fail)
    );

    always #5 clock = ~clock;

    // Body RAM with one-cycle registered read.
    always @(posedge clock) begin
        seg_x <= body_x[seg_idx];
        seg_y <= body_y[seg_idx];
    end

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    function automatic bit grid_ok(input int c, input int cells);
        return (c >= 2) && (((c - 2) % 25) == 0) && (((c - 2) / 25) < cells);
    endfunction

    function automatic bit on_body(input int x, input int y, input int n);
        bit h = 1'b0;
        for (int i = 0; i < n; i++)
            if (int'(body_x[i]) == x && int'(body_y[i]) == y) h = 1'b1;
        return h;
    endfunction

    task automatic free_cell(input int n, output int x, output int y);
        do begin
            x = $urandom_range(0, 20) * 25 + 2;
            y = $urandom_range(0, 19) * 25 + 2;
        end while (on_body(x, y, n));
    endtask

    // Reference model: builds the per-cycle input schedule (index t drives
    // the cycle ending at edge base+t) and derives the expected result.
    // A bad-grid candidate costs one cycle; a body hit costs the sample plus
    // n+2 scan cycles; an accepted one is visible n+3 edges after sampling.
    task automatic plan(input int base, input int n, output exp_t e, output int tmax);
        int t, rej, attempts, x, y, k;
        bit fin;
        t = 0; rej = 0; attempts = 0; fin = 1'b0;
        e.pf_edge = 32'h7fff_ffff;
        rx_at.delete(); ry_at.delete(); len_at.delete(); eat_at.delete();
        while (!fin) begin
            if (force_hits > 0 && n > 0) begin
                k = $urandom_range(0, n - 1); x = body_x[k]; y = body_y[k]; force_hits--;
            end else if (fqx.size() > 0) begin
                x = fqx.pop_front(); y = fqy.pop_front();
            end else if (attempts >= 12) begin
                free_cell(n, x, y);
            end else begin
                case ($urandom_range(0, 4))
                    0: begin x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); end
                    1: begin x = $urandom_range(0, 20) * 25 + 2 + $urandom_range(1, 24);
                             y = $urandom_range(0, 19) * 25 + 2; end
                    2: begin x = 527; y = $urandom_range(0, 19) * 25 + 2; end
                    3: begin
                        if (n > 0) begin k = $urandom_range(0, n - 1); x = body_x[k]; y = body_y[k]; end
                        else free_cell(n, x, y);
                    end
                    default: begin
                        if ($urandom_range(0, 1) == 0) free_cell(n, x, y);
                        else begin x = $urandom_range(0, 20) * 25 + 2; y = 502; end
                    end
                endcase
            end
            attempts++;
            rx_at.push_back(x); ry_at.push_back(y); len_at.push_back(n);
            eat_at.push_back($urandom_range(0, 7) == 0);
            if (!(grid_ok(x, 21) && grid_ok(y, 20))) begin
                rej++;
                if (rej == 16) e.pf_edge = base + t;
                t += 1;
            end else if (on_body(x, y, n)) begin
                rej++;
                if (rej == 16) e.pf_edge = base + t + n + 2;
                for (int j = 0; j < n + 2; j++) begin
                    rx_at.push_back($urandom_range(0, 1023)); ry_at.push_back($urandom_range(0, 1023));
                    len_at.push_back($urandom_range(0, 127)); eat_at.push_back($urandom_range(0, 3) == 0);
                end
                t += n + 3;
            end else begin
                for (int j = 0; j < n + 3; j++) begin
                    rx_at.push_back($urandom_range(0, 1023)); ry_at.push_back($urandom_range(0, 1023));
                    len_at.push_back($urandom_range(0, 127)); eat_at.push_back($urandom_range(0, 3) == 0);
                end
                e.fx = x; e.fy = y;
                e.commit_edge = base + t + n + 3;
                tmax = t + n + 3;
                fin = 1'b1;
            end
        end
    endtask

    task automatic drive(input int last);
        for (int t = 0; t <= last; t++) begin
            randNumX  = 10'(rx_at[t]);
            randNumY  = 10'(ry_at[t]);
            snake_len = 7'(len_at[t]);
            eaten     = eat_at[t];
            @(posedge clock); #1;
        end
        eaten = 1'b0;
    endtask

    task automatic place_eaten(input int n, input int stop_at);
        exp_t e;
        int   tmax, base;
        base = edge_n + 2;
        plan(base, n, e, tmax);
        eaten = 1'b1; snake_len = 7'(n);
        @(posedge clock); #1;
        eaten = 1'b0;
        sbq.push_back(e);
`ifdef FOOD_EAT_COUNT_EN
        exp_eat++;
        chk("eat_count", int'(eat_count), exp_eat & 16'hFFFF);
`endif
        if (stop_at >= 0) begin
            eat_at[2] = 1'b1;
            drive(stop_at);
        end else begin
            drive(tmax);
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        end
    endtask

    task automatic place_reset(input int n);
        exp_t e;
        int   tmax;
        plan(edge_n + 1, n, e, tmax);
        reset = 1'b0;
        sbq.push_back(e);
        drive(tmax);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_foodX"}, int'(foodX), 27);
        chk({tag, "_foodY"}, int'(foodY), 27);
        chk({tag, "_food_valid"}, int'(food_valid), 0);
        chk({tag, "_place_fail"}, int'(place_fail), 0);
        chk({tag, "_seg_idx"}, int'(seg_idx), 0);
`ifdef FOOD_EAT_COUNT_EN
        chk({tag, "_eat_count"}, int'(eat_count), 0);
`endif
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clock) begin : mon
        exp_t h;
        if (reset === 1'b0) begin
            if (sbq.size() == 0) begin
                chk("idle_food_valid", int'(food_valid), 1);
                chk("idle_place_fail", int'(place_fail), 0);
            end else begin
                h = sbq[0];
                if (food_valid) begin
                    void'(sbq.pop_front());
                    chk("commit_edge", edge_n, h.commit_edge);
                    chk("foodX", int'(foodX), h.fx);
                    chk("foodY", int'(foodY), h.fy);
                    chk("commit_place_fail", int'(place_fail), 0);
                end else if (edge_n >= h.commit_edge) begin
                    chk("food_valid_by_commit", int'(food_valid), 1);
                    void'(sbq.pop_front());
                end else begin
                    chk("place_fail", int'(place_fail), (edge_n >= h.pf_edge) ? 1 : 0);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, cx;
        reset = 1'b1; eaten = 1'b0; randNumX = '0; randNumY = '0; snake_len = '0;
        for (int i = 0; i < 64; i++) begin body_x[i] = 10'd0; body_y[i] = 10'd0; end
        repeat (3) @(posedge clock);
        #1;
        reset_checks("rst");

        // Out of reset, empty snake: committed 4 edges after release.
        fqx = '{27}; fqy = '{27};
        place_reset(0);

        // Three-segment body along row y=52.
        body_x[0] = 10'd52; body_x[1] = 10'd77; body_x[2] = 10'd102;
        for (int i = 0; i < 3; i++) body_y[i] = 10'd52;
        fqx = '{127}; fqy = '{52};
        place_eaten(3, -1);
        fqx = '{77, 127}; fqy = '{52, 77};
        place_eaten(3, -1);
        fqx = '{527, 30, 27, 2}; fqy = '{27, 27, 502, 2};
        place_eaten(3, -1);

        // Twenty body hits in a row, then a clean cell.
        force_hits = 20;
        fqx = '{2}; fqy = '{27};
        place_eaten(3, -1);

        // Long body, clean candidate; reset lands mid-scan.
        for (int i = 0; i < 64; i++) begin
            body_x[i] = 10'($urandom_range(0, 20) * 25 + 2);
            body_y[i] = 10'($urandom_range(0, 19) * 25 + 2);
        end
        free_cell(20, n, cx);
        fqx = '{n}; fqy = '{cx};
        place_eaten(20, 4);
        #2 reset = 1'b1;
        #1 reset_checks("midscan");
        sbq.delete();
`ifdef FOOD_EAT_COUNT_EN
        exp_eat = 0;
`endif
        @(posedge clock); #1;
        place_reset($urandom_range(0, 10));

        // Random placements including the empty and full-length snakes.
        for (int r = 0; r < 24; r++) begin
            case (r % 4)
                0: n = 0;
                1: n = 64;
                default: n = $urandom_range(1, 63);
            endcase
            for (int i = 0; i < 64; i++) begin
                body_x[i] = 10'($urandom_range(0, 20) * 25 + 2);
                body_y[i] = 10'($urandom_range(0, 19) * 25 + 2);
            end
            place_eaten(n, -1);
        end

        repeat (2) @(posedge clock);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
